ram_responder: RTL and testbench

Single-port, word-organised RAM model with programmable access latency. It answers the RAM side of the cache-control interface: it accepts ramREN/ramWEN/ramaddr/ramstore from the memory controller and returns ramstate and ramload. It is used as the simulation and FPGA backing memory under memory_control. Its BUSY/ACCESS sequencing sets when the controller may release iwait or dwait.

---
 rtl/ram_responder.sv | 98 +++++++++
 tb/tb_ram_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - word-organised RAM model answering the cache-control RAM interface with programmable latency
// The latency count only advances while the exact same request is held; any change restarts it.
module ram_responder #(
  parameter int LAT       = 2,
  parameter int ADDR_BITS = 14
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam int CW    = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int SIGW  = 2 + 30 + 32;

  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          addr_hi;
  logic                 active;
  logic                 err;
  logic [SIGW-1:0]      sig;
  logic [SIGW-1:0]      latched;
  logic                 valid;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        age;
  logic [CW-1:0]        cnt_next;
  logic                 reached;
  logic                 same;
  logic                 commit;

  assign idx     = ramaddr[ADDR_BITS+1:2];
  assign addr_hi = ramaddr >> (ADDR_BITS + 2);
  assign active  = ramREN | ramWEN;
  assign err     = (ramREN & ramWEN) | (|addr_hi);

  // Store data only participates in the signature for writes.
  assign sig  = {ramREN, ramWEN, ramaddr[31:2], (ramWEN ? ramstore : 32'h0)};
  assign same = valid && (sig == latched);
  assign age  = same ? cnt : '0;

  if (LAT == 0) begin : g_lat0
    assign reached  = 1'b1;
    assign cnt_next = '0;
  end else begin : g_latn
    localparam logic [CW-1:0] LAT_C = CW'(LAT);
    assign reached  = (age >= LAT_C);
    assign cnt_next = reached ? LAT_C : age + 1'b1;
  end

  always_comb begin
    ramstate = BUSY;
    if (!active)      ramstate = FREE;
    else if (err)     ramstate = ERROR;
    else if (reached) ramstate = ACCESS;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid   <= 1'b0;
      cnt     <= '0;
      latched <= '0;
    end else if (active && !err) begin
      valid   <= 1'b1;
      cnt     <= cnt_next;
      latched <= sig;
    end else begin
      valid   <= 1'b0;
      cnt     <= '0;
    end
  end

  assign commit = (ramstate == ACCESS) && ramWEN;

  // One register per word so the whole array clears on reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [31:0] word;
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
        word <= 32'h0;
      else if (commit && (idx == ADDR_BITS'(g)))
        word <= ramstore;
    end
    assign mem[g] = word;
  end

  assign ramload = mem[idx];

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder at LAT=2 and LAT=0
module tb_ram_responder;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef struct {
    bit          dut;
    logic [1:0]  st;
    bit          chk;
    logic [31:0] load;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_ren, a_wen, b_ren, b_wen;
  logic [31:0] a_addr, a_store, b_addr, b_store;
  logic [31:0] a_load, b_load;
  logic [1:0]  a_state, b_state;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  ram_responder #(.LAT(2), .ADDR_BITS(14)) dut_a (
    .CLK(clk), .nRST(rst_n), .ramREN(a_ren), .ramWEN(a_wen),
    .ramaddr(a_addr), .ramstore(a_store), .ramload(a_load), .ramstate(a_state)
  );

  ram_responder #(.LAT(0), .ADDR_BITS(14)) dut_b (
    .CLK(clk), .nRST(rst_n), .ramREN(b_ren), .ramWEN(b_wen),
    .ramaddr(b_addr), .ramstore(b_store), .ramload(b_load), .ramstate(b_state)
  );

  task automatic push(input bit d, input logic [1:0] st, input bit chk,
                      input logic [31:0] ld, input string nm);
    exp_t e;
    e.dut = d; e.st = st; e.chk = chk; e.load = ld;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drive(input bit d, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] s);
    if (d) begin
      b_ren = r; b_wen = w; b_addr = a; b_store = s;
    end else begin
      a_ren = r; a_wen = w; a_addr = a; a_store = s;
    end
  endtask

  // One cycle of stimulus: apply inputs just after the edge and queue the expectation.
  task automatic step(input bit d, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] s,
                      input logic [1:0] st, input bit chk,
                      input logic [31:0] ld, input string nm);
    @(posedge clk); #1;
    drive(d, r, w, a, s);
    push(d, st, chk, ld, nm);
  endtask

  task automatic read3(input bit d, input logic [31:0] a, input logic [31:0] ld,
                       input string nm);
    step(d, 1, 0, a, 0, BUSY, 0, 0, {nm, "_b0"});
    step(d, 1, 0, a, 0, BUSY, 0, 0, {nm, "_b1"});
    step(d, 1, 0, a, 0, ACCESS, 1, ld, {nm, "_acc"});
  endtask

  task automatic write3(input bit d, input logic [31:0] a, input logic [31:0] s,
                        input string nm);
    step(d, 0, 1, a, s, BUSY, 0, 0, {nm, "_b0"});
    step(d, 0, 1, a, s, BUSY, 0, 0, {nm, "_b1"});
    step(d, 0, 1, a, s, ACCESS, 0, 0, {nm, "_acc"});
  endtask

  exp_t        m_e;
  string       m_nm;
  logic [1:0]  m_st;
  logic [31:0] m_ld;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e  = exp_q.pop_front();
      m_nm = name_q.pop_front();
      m_st = m_e.dut ? b_state : a_state;
      m_ld = m_e.dut ? b_load  : a_load;
      checks++;
      if (m_st !== m_e.st) begin
        failures++;
        $display("FAIL %s state: got %0d expected %0d", m_nm, m_st, m_e.st);
      end
      if (m_e.chk) begin
        checks++;
        if (m_ld !== m_e.load) begin
          failures++;
          $display("FAIL %s load: got %h expected %h", m_nm, m_ld, m_e.load);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    push(0, FREE, 1, 32'h0, "reset_hold");
    @(negedge clk); #1;
    rst_n = 1'b1;

    step(0, 0, 0, 32'h0, 0, FREE, 1, 32'h0, "idle");
    read3(0, 32'h100, 32'h0, "rd100");

    write3(0, 32'h40, 32'hDEADBEEF, "wr40");
    read3(0, 32'h40, 32'hDEADBEEF, "rd40");
    step(0, 1, 0, 32'h40, 0, ACCESS, 1, 32'hDEADBEEF, "rd40_persist");

    step(0, 1, 0, 32'h80, 0, BUSY, 0, 0, "rd80_b0");
    read3(0, 32'h84, 32'h0, "rd84_restart");

    step(0, 0, 1, 32'h10, 32'h1234, BUSY, 0, 0, "wr10_b0");
    step(0, 0, 0, 32'h0, 0, FREE, 0, 0, "wr10_drop");
    read3(0, 32'h10, 32'h0, "rd10_abandoned");

    step(0, 0, 1, 32'h44, 32'h1, BUSY, 0, 0, "wr44_d1");
    write3(0, 32'h44, 32'h2, "wr44_d2");
    read3(0, 32'h44, 32'h2, "rd44");

    // Reset arrives while a write is one cycle into BUSY.
    step(0, 0, 1, 32'h20, 32'h5678, BUSY, 0, 0, "wr20_b0");
    @(posedge clk); #1;
    rst_n = 1'b0;
    push(0, BUSY, 0, 0, "wr20_in_reset");
    @(negedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 1, 32'h20, 32'h5678, BUSY, 0, 0, "wr20_restart");
    step(0, 0, 0, 32'h0, 0, FREE, 0, 0, "wr20_drop");
    read3(0, 32'h20, 32'h0, "rd20_lost");
    read3(0, 32'h40, 32'h0, "rd40_cleared");

    step(0, 1, 1, 32'h40, 32'h1111, ERROR, 0, 0, "renwen_e0");
    step(0, 1, 1, 32'h40, 32'h1111, ERROR, 0, 0, "renwen_e1");
    read3(0, 32'h40, 32'h0, "rd40_noerrwrite");

    step(0, 0, 1, 32'h0001_0000, 32'hCAFE, ERROR, 0, 0, "wr_oor");
    step(0, 1, 0, 32'h0001_0000, 0, ERROR, 0, 0, "rd_oor");
    write3(0, 32'h0000_FFFC, 32'hCAFE, "wrFFFC");
    read3(0, 32'h0000_FFFC, 32'hCAFE, "rdFFFC");
    read3(0, 32'h0, 32'h0, "rd0_noalias");
    step(0, 0, 0, 32'h0, 0, FREE, 0, 0, "a_idle");

    step(1, 0, 0, 32'h0, 0, FREE, 1, 32'h0, "b_idle");
    step(1, 1, 0, 32'h0, 0, ACCESS, 1, 32'h0, "b_rd0");
    step(1, 0, 1, 32'h4, 32'hA5A5A5A5, ACCESS, 1, 32'h0, "b_wr4");
    step(1, 1, 0, 32'h4, 0, ACCESS, 1, 32'hA5A5A5A5, "b_rd4");
    step(1, 0, 0, 32'h0, 0, FREE, 0, 0, "b_done");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
